// File: rtl/audio_pkg.sv
// audio_pkg: shared sample widths and stereo frame types for the audio path
package audio_pkg;
  localparam int SAMPLE_W = 16;
  localparam int FRAME_SLOTS = 2 * SAMPLE_W;
  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef struct packed {
    sample_t left;
    sample_t right;
  } stereo_t;
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: divides the system clock into bclk and flags the clock ending each high phase
module i2s_bclk_gen #(
  parameter int BCLK_DIV = 8
) (
  input  logic clock,
  input  logic reset_n,
  output logic bclk,
  output logic fall
);
  localparam int CW = (BCLK_DIV > 2) ? $clog2(BCLK_DIV) : 1;
  logic [CW-1:0] cnt;
  logic tc;
  assign tc = cnt == CW'(BCLK_DIV - 1);
  // fall is high in the cycle whose closing edge drives bclk low
  assign fall = tc && bclk;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt  <= '0;
      bclk <= 1'b0;
    end else begin
      cnt  <= tc ? '0 : cnt + 1'b1;
      bclk <= bclk ^ tc;
    end
  end
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: Philips I2S master transmitter with a one-frame holding register.
// Define I2S_TX_HOLD_EN to repeat the last transmitted pair on underrun instead of zeros.
module i2s_tx
  import audio_pkg::*;
#(
  parameter int BCLK_DIV = 8
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic [SAMPLE_W-1:0] in_left,
  input  logic [SAMPLE_W-1:0] in_right,
  input  logic                in_valid,
  output logic                in_ready,
  output logic                bclk,
  output logic                lrclk,
  output logic                sdata,
  output logic                underrun
);
  localparam int SW = $clog2(FRAME_SLOTS);
  logic fall, load, accept, full, full_n;
  logic [SW-1:0] slot, slot_n;
  logic [FRAME_SLOTS-1:0] shift;
  stereo_t hold, src;
  i2s_bclk_gen #(.BCLK_DIV(BCLK_DIV)) u_bclk (
    .clock  (clock),
    .reset_n(reset_n),
    .bclk   (bclk),
    .fall   (fall)
  );
  assign load     = fall && slot == SW'(FRAME_SLOTS - 1);
  assign accept   = in_valid && in_ready;
  assign underrun = load && !full;
  assign slot_n   = slot + 1'b1;
  assign full_n   = accept ? 1'b1 : load ? 1'b0 : full;
`ifdef I2S_TX_HOLD_EN
  stereo_t last;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) last <= '0;
    else if (load && full) last <= hold;
  end
  assign src = full ? hold : last;
`else
  assign src = full ? hold : '0;
`endif
  // Serial outputs only move on the fall strobe so the DAC samples them on bclk rise
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      slot     <= SW'(FRAME_SLOTS - 1);
      full     <= 1'b0;
      in_ready <= 1'b1;
      hold     <= '0;
      shift    <= '0;
      sdata    <= 1'b0;
      lrclk    <= 1'b0;
    end else begin
      full     <= full_n;
      in_ready <= !full_n;
      if (accept) hold <= {in_left, in_right};
      if (fall) begin
        slot  <= slot_n;
        lrclk <= slot_n >= SW'(SAMPLE_W - 1) && slot_n <= SW'(FRAME_SLOTS - 2);
        sdata <= load ? src[FRAME_SLOTS-1] : shift[FRAME_SLOTS-1];
        shift <= load ? {src[FRAME_SLOTS-2:0], 1'b0} : {shift[FRAME_SLOTS-2:0], 1'b0};
      end
    end
  end
endmodule

// File: tb/tb_i2s_tx.sv
// tb_i2s_tx: directed stimulus with an accepted-pair scoreboard checked slot by slot against the serial output
module tb_i2s_tx;
  logic clock, reset_n, in_valid, in_ready, bclk, lrclk, sdata, underrun;
  logic [15:0] in_left, in_right;
  int checks = 0, errors = 0, cyc = 0, slot = 31, last_load = 0, und_cnt = 0;
  logic [31:0] q[$];
  logic [31:0] cur = 0, last_pair = 0, pair_p = 0;
  logic pb = 0, acc_p = 0, und_p = 0;

  i2s_tx #(.BCLK_DIV(4)) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .in_left (in_left),
    .in_right(in_right),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .bclk    (bclk),
    .lrclk   (lrclk),
    .sdata   (sdata),
    .underrun(underrun)
  );

  initial clock = 0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: accepted pairs queue until a frame load; every fall strobe is checked against the model frame
  always @(negedge clock) begin
    logic fell, load, exp_und;
    if (!reset_n) begin
      q.delete();
      slot = 31; cur = 0; last_pair = 0; pb = 0; acc_p = 0; und_p = 0;
    end else begin
      fell = pb && !bclk;
      load = fell && slot == 31;
      exp_und = 0;
      if (fell) slot = (slot == 31) ? 0 : slot + 1;
      if (load) begin
        last_load = cyc;
        if (q.size() != 0) begin
          cur = q.pop_front();
          last_pair = cur;
        end else begin
          exp_und = 1;
`ifdef I2S_TX_HOLD_EN
          cur = last_pair;
`else
          cur = 0;
`endif
        end
      end
      chk("underrun", {31'b0, und_p}, {31'b0, exp_und});
      if (und_p) und_cnt++;
      if (acc_p) q.push_back(pair_p);
      if (fell) begin
        chk("lrclk", {31'b0, lrclk}, {31'b0, slot >= 15 && slot <= 30});
        chk("sdata", {31'b0, sdata}, {31'b0, cur[31-slot]});
      end
      chk("in_ready", {31'b0, in_ready}, {31'b0, q.size() == 0});
      pb = bclk;
      und_p = underrun;
      acc_p = in_valid && in_ready;
      pair_p = {in_left, in_right};
    end
  end

  task automatic send(input logic [15:0] l, input logic [15:0] r, output int acc);
    int n = 0;
    in_left = l; in_right = r; in_valid = 1;
    @(negedge clock);
    while (!in_ready && n < 600) begin
      @(negedge clock);
      n++;
    end
    chk("send_timeout", {31'b0, n < 600}, 32'd1);
    @(posedge clock); #1;
    acc = cyc;
    in_valid = 0;
  endtask

  task automatic frames(input int f);
    repeat (f * 256) @(posedge clock);
    #1;
  endtask

  initial begin
    int n, acc1, acc2, u0;
    reset_n = 0; in_valid = 0; in_left = 0; in_right = 0;
    repeat (3) @(posedge clock);
    #1;
    chk("rst_bclk", {31'b0, bclk}, 32'd0);
    chk("rst_lrclk", {31'b0, lrclk}, 32'd0);
    chk("rst_sdata", {31'b0, sdata}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_underrun", {31'b0, underrun}, 32'd0);
    reset_n = 1;
    in_left = 16'hA5A5; in_right = 16'h5A5A; in_valid = 1;
    @(posedge clock); #1;
    in_valid = 0;
    n = 1;
    while (!bclk && n < 20) begin @(posedge clock); #1; n++; end
    chk("first_rise", n, 4);
    while (bclk && n < 20) begin @(posedge clock); #1; n++; end
    chk("first_fall", n, 8);
    while (!bclk && n < 20) begin @(posedge clock); #1; n++; end
    chk("second_rise", n, 12);
    frames(2);
    u0 = und_cnt;
    in_left = 16'h4E20; in_right = 16'h4E20; in_valid = 1;
    frames(3);
    in_valid = 0;
    chk("feed_no_underrun", und_cnt, u0);
    frames(2);
    send(16'h0001, 16'hFFFF, acc1);
    send(16'h8000, 16'h7FFF, acc2);
    chk("b2b_accept_after_load", acc2, last_load + 1);
    frames(3);
    send(16'h7FFF, 16'h8000, acc1);
    frames(3);
    send(16'h1234, 16'h4321, acc1);
    frames(1);
    send(16'h0F0F, 16'hF0F0, acc1);
    n = 0;
    while (slot != 10 && n < 600) begin @(negedge clock); n++; end
    chk("slot10_timeout", {31'b0, n < 600}, 32'd1);
    @(posedge clock); #1;
    reset_n = 0;
    #1;
    chk("mid_rst_bclk", {31'b0, bclk}, 32'd0);
    chk("mid_rst_lrclk", {31'b0, lrclk}, 32'd0);
    chk("mid_rst_sdata", {31'b0, sdata}, 32'd0);
    chk("mid_rst_ready", {31'b0, in_ready}, 32'd1);
    repeat (3) @(posedge clock);
    #1;
    reset_n = 1;
    u0 = und_cnt;
    frames(2);
    chk("post_rst_underruns", und_cnt, u0 + 2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
